// File: rtl/npc_sim_pkg.sv
// Shared types and constants for the NPC retirement-side simulation controller.
package npc_sim_pkg;

  typedef enum logic [1:0] {
    SIM_RUN,
    SIM_DRAIN,
    SIM_HALT
  } sim_state_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [31:0] EXIT_WDOG   = 32'hFFFF_FFFF;

endpackage

// File: rtl/npc_sim_wdog.sv
// Commit-stall watchdog: down-counter reloaded on clear, expires when LIMIT
// consecutive enabled cycles pass without a clear. LIMIT == 0 disables it.
module npc_sim_wdog #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LOAD = W'(LIMIT);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= LOAD;
    end else if (i_clear) begin
      r_count <= LOAD;
    end else if (i_enable && (r_count > W'(1))) begin
      r_count <= r_count - W'(1);
    end
  end

  // A clear on the expiring cycle wins, so a last-moment retire keeps the core alive.
  assign o_expire = (LIMIT != 0) && i_enable && !i_clear && (r_count == W'(1));

endmodule

// File: rtl/npc_sim_ctrl.sv
// Retirement-side simulation controller: accepts WBU commits, pulses io_sync,
// ends simulation on ebreak (after LSU drain) or on a commit-stall watchdog.
module npc_sim_ctrl
  import npc_sim_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned WDOG_CYCLES = 1_000_000,
  parameter logic [31:0] EBREAK_INST = npc_sim_pkg::EBREAK_INST
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             commit_valid,
  output logic             commit_ready,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [31:0]      commit_inst,
  input  logic [XLEN-1:0]  commit_a0,
  input  logic             lsu_busy,
  output logic             halt_req,
  output logic             io_sync,
  output logic             io_simEnd,
  output logic [XLEN-1:0]  exit_code,
  output logic             good_trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  sim_state_e r_state;
  sim_state_e w_next_state;

  logic             r_sync;
  logic [XLEN-1:0]  r_exit_code;
  logic             r_wdog_fired;
  logic             r_good_trap;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  logic             w_retire;
  logic             w_is_ebreak;
  logic             w_wdog_expire;
  logic [XLEN-1:0]  w_exit_next;
  logic             w_fired_next;

  // The PC is carried on the commit bus for tracing only.
  logic w_unused_pc;
  assign w_unused_pc = ^commit_pc;

  assign w_retire    = commit_valid && commit_ready;
  assign w_is_ebreak = (commit_inst == EBREAK_INST);

  npc_sim_wdog #(
    .LIMIT(WDOG_CYCLES)
  ) u_wdog (
    .clk      (clock),
    .rst_n    (reset),
    .i_clear  (w_retire),
    .i_enable ((r_state == SIM_RUN) && !w_retire),
    .o_expire (w_wdog_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= SIM_RUN;
    else        r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_exit_next  = r_exit_code;
    w_fired_next = r_wdog_fired;
    unique case (r_state)
      SIM_RUN: begin
        if (w_retire && w_is_ebreak) begin
          w_exit_next  = commit_a0;
          w_next_state = lsu_busy ? SIM_DRAIN : SIM_HALT;
        end else if (w_wdog_expire) begin
          w_exit_next  = XLEN'(EXIT_WDOG);
          w_fired_next = 1'b1;
          w_next_state = SIM_HALT;
        end
      end
      SIM_DRAIN: begin
        if (!lsu_busy) w_next_state = SIM_HALT;
      end
      SIM_HALT: w_next_state = SIM_HALT;
      default:  w_next_state = SIM_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync        <= 1'b0;
      r_exit_code   <= '0;
      r_wdog_fired  <= 1'b0;
      r_good_trap   <= 1'b0;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      // io_sync pulses once per retire and is pinned high once halted.
      r_sync       <= w_retire || (w_next_state == SIM_HALT);
      r_exit_code  <= w_exit_next;
      r_wdog_fired <= w_fired_next;
      r_good_trap  <= (w_next_state == SIM_HALT) && (w_exit_next == '0) && !w_fired_next;
      if (r_state != SIM_HALT) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire)            r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign commit_ready = (r_state == SIM_RUN);
  assign halt_req     = (r_state != SIM_RUN);
  assign io_simEnd    = (r_state == SIM_HALT);
  assign io_sync      = r_sync;
  assign exit_code    = r_exit_code;
  assign good_trap    = r_good_trap;
  assign cycle_cnt    = r_cycle_cnt;
  assign instret_cnt  = r_instret_cnt;

endmodule
